conv_encoder_punct: RTL and testbench

- 802.11a convolutional encoder with puncturing. Sits directly downstream of the scrambler and consumes its serial bit stream.
- Encodes at K=7, rate 1/2 with generators g0=133o and g1=171o, then punctures to rate 2/3 or 3/4.
- Emits one coded bit per clock toward the interleaver.
- Applies backpressure to the upstream stage through a ready output.

---
 rtl/phy_pkg.sv | 41 ++++
 rtl/conv_bit_fifo2.sv | 47 ++++
 rtl/conv_encoder_punct.sv | 117 +++++++++++
 tb/tb_conv_encoder_punct.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: rate codes, default generator polynomials and the
// puncturing keep-mask used by the convolutional encoder.
package phy_pkg;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    localparam logic [6:0] G0_DEFAULT = 7'o133;
    localparam logic [6:0] G1_DEFAULT = 7'o171;

    // Code 2'b11 is not a real rate; it behaves as rate 1/2.
    function automatic logic [1:0] norm_rate(input logic [1:0] rate);
        return (rate == 2'b11) ? RATE_1_2 : rate;
    endfunction

    // Last phase before the puncture pattern wraps back to phase 0.
    function automatic logic [1:0] phase_last(input logic [1:0] rate);
        case (rate)
            RATE_2_3: return 2'd1;
            RATE_3_4: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    // Returns {keepA, keepB} for one mother-code pair.
    function automatic logic [1:0] keep_mask(input logic [1:0] rate, input logic [1:0] phase);
        case (rate)
            RATE_2_3: return (phase == 2'd1) ? 2'b10 : 2'b11;
            RATE_3_4: begin
                case (phase)
                    2'd1:    return 2'b10;
                    2'd2:    return 2'b01;
                    default: return 2'b11;
                endcase
            end
            default:  return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/conv_bit_fifo2.sv
// Two-entry bit FIFO: one pop and a push of 0..2 bits per cycle, entry 0 is
// the head. The caller guarantees the occupancy never exceeds two.
module conv_bit_fifo2 (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [1:0] i_push_n,
    input  logic [1:0] i_push_bits,
    input  logic       i_pop,
    output logic       o_head,
    output logic [1:0] o_count
);

    logic [1:0] r_mem;
    logic [1:0] r_count;
    logic [1:0] w_mem_nxt;
    logic [1:0] w_rem_n;
    logic       w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign w_rem_n = r_count - {1'b0, w_pop};

    // Survivors of the pop move to the front, pushed bits fill in behind them.
    always_comb begin
        w_mem_nxt = r_mem;
        case (w_rem_n)
            2'd0:    w_mem_nxt = i_push_bits;
            2'd1:    w_mem_nxt = {i_push_bits[0], (w_pop ? r_mem[1] : r_mem[0])};
            default: w_mem_nxt = r_mem;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_rem_n + i_push_n;
        end
    end

    always_ff @(posedge clock) begin
        r_mem <= w_mem_nxt;
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;

endmodule

// File: rtl/conv_encoder_punct.sv
// 802.11a K=7 rate-1/2 convolutional encoder with 2/3 and 3/4 puncturing,
// serialising kept bits through a 2-entry FIFO at one coded bit per clock.
module conv_encoder_punct
    import phy_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEFAULT,
    parameter logic [6:0] G1 = G1_DEFAULT
) (
    input  logic       clock,
    input  logic       ConvEncoder_Reset_n,
    input  logic       ConvEncoder_Start,
    input  logic [1:0] ConvEncoder_Rate,
    input  logic       ConvEncoder_DataIN,
    input  logic       ConvEncoder_DataIN_VALID,
    output logic       ConvEncoder_DataIN_READY,
    output logic       ConvEncoder_DataOUT,
    output logic       ConvEncoder_DataOUTVALID
);

    logic [5:0] r_sreg;
    logic [1:0] r_phase;
    logic [1:0] r_rate;
    logic       r_dout;
    logic       r_dvld;

    logic [1:0] w_count;
    logic       w_head;
    logic       w_pop;
    logic       w_accept;
    logic [5:0] w_sreg_eff;
    logic [1:0] w_phase_eff;
    logic [1:0] w_rate_eff;
    logic [1:0] w_phase_nxt;
    logic [6:0] w_win;
    logic       w_a;
    logic       w_b;
    logic [1:0] w_keep;
    logic [1:0] w_push_n;
    logic [1:0] w_push_bits;

    assign ConvEncoder_DataIN_READY = (w_count != 2'd2);
    assign w_accept = ConvEncoder_DataIN_VALID && ConvEncoder_DataIN_READY;
    assign w_pop    = (w_count != 2'd0);

    // A Start in the same cycle as an accept encodes from the cleared state.
    assign w_sreg_eff  = ConvEncoder_Start ? 6'd0 : r_sreg;
    assign w_phase_eff = ConvEncoder_Start ? 2'd0 : r_phase;
    assign w_rate_eff  = ConvEncoder_Start ? norm_rate(ConvEncoder_Rate) : r_rate;

    // Generator bit 6 taps the current input, bit 0 the oldest delay.
    assign w_win = {ConvEncoder_DataIN, w_sreg_eff[0], w_sreg_eff[1], w_sreg_eff[2],
                    w_sreg_eff[3], w_sreg_eff[4], w_sreg_eff[5]};
    assign w_a   = ^(w_win & G0);
    assign w_b   = ^(w_win & G1);

    assign w_keep      = w_accept ? keep_mask(w_rate_eff, w_phase_eff) : 2'b00;
    assign w_phase_nxt = (w_phase_eff == phase_last(w_rate_eff)) ? 2'd0 : w_phase_eff + 2'd1;

    always_comb begin
        w_push_n    = 2'd0;
        w_push_bits = 2'b00;
        case (w_keep)
            2'b11: begin
                w_push_n    = 2'd2;
                w_push_bits = {w_b, w_a};
            end
            2'b10: begin
                w_push_n    = 2'd1;
                w_push_bits = {1'b0, w_a};
            end
            2'b01: begin
                w_push_n    = 2'd1;
                w_push_bits = {1'b0, w_b};
            end
            default: begin
                w_push_n    = 2'd0;
                w_push_bits = 2'b00;
            end
        endcase
    end

    conv_bit_fifo2 u_fifo (
        .clock       (clock),
        .rst_n       (ConvEncoder_Reset_n),
        .i_push_n    (w_push_n),
        .i_push_bits (w_push_bits),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clock or negedge ConvEncoder_Reset_n) begin
        if (!ConvEncoder_Reset_n) begin
            r_sreg  <= 6'd0;
            r_phase <= 2'd0;
            r_rate  <= RATE_1_2;
            r_dout  <= 1'b0;
            r_dvld  <= 1'b0;
        end else begin
            if (ConvEncoder_Start) begin
                r_sreg  <= 6'd0;
                r_phase <= 2'd0;
                r_rate  <= norm_rate(ConvEncoder_Rate);
            end
            if (w_accept) begin
                r_sreg  <= {w_sreg_eff[4:0], ConvEncoder_DataIN};
                r_phase <= w_phase_nxt;
            end
            r_dvld <= w_pop;
            r_dout <= w_pop & w_head;
        end
    end

    assign ConvEncoder_DataOUT      = r_dout;
    assign ConvEncoder_DataOUTVALID = r_dvld;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: directed impulse streams plus randomized
// traffic scored cycle by cycle against a queue-based reference model.
module tb_conv_encoder_punct;

    localparam logic [6:0] TG0 = 7'o133;
    localparam logic [6:0] TG1 = 7'o171;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic [1:0] rate;
    logic       din;
    logic       vin;
    logic       rdy;
    logic       dout;
    logic       dvld;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit   q[$];
    bit   hist[$];
    int   mrate;
    logic e_dout;
    logic e_vld;
    logic m_acc;
    int   m_n;
    logic m_a;
    logic m_b;
    logic [1:0] m_k;

    logic chk_en = 1'b0;
    logic cap_en = 1'b0;
    bit   cap[$];
    logic bp_mon = 1'b0;
    logic bp_seen = 1'b0;
    int   bp_gaps = 0;

    conv_encoder_punct dut (
        .clock                    (clock),
        .ConvEncoder_Reset_n      (rst_n),
        .ConvEncoder_Start        (start),
        .ConvEncoder_Rate         (rate),
        .ConvEncoder_DataIN       (din),
        .ConvEncoder_DataIN_VALID (vin),
        .ConvEncoder_DataIN_READY (rdy),
        .ConvEncoder_DataOUT      (dout),
        .ConvEncoder_DataOUTVALID (dvld)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Convolution of the input history since the last Start with generator g.
    function automatic logic parity_at(input int n, input logic [6:0] g);
        logic x;
        x = 1'b0;
        for (int j = 0; j <= 6; j++)
            if (g[6-j] && (n - j) >= 0) x = x ^ hist[n-j];
        return x;
    endfunction

    // Puncture pattern indexed by input count since Start: {keepA, keepB}.
    function automatic logic [1:0] tb_keep(input int r, input int idx);
        if (r == 1) return ((idx % 2) == 0) ? 2'b11 : 2'b10;
        if (r == 2) begin
            case (idx % 3)
                0:       return 2'b11;
                1:       return 2'b10;
                default: return 2'b01;
            endcase
        end
        return 2'b11;
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                hist.delete();
                mrate  = 0;
                e_vld  = 1'b0;
                e_dout = 1'b0;
            end else begin
                m_acc = vin && (q.size() != 2);
                if (start) begin
                    hist.delete();
                    mrate = (rate == 2'b11) ? 0 : int'(rate);
                end
                if (q.size() > 0) begin
                    e_dout = q.pop_front();
                    e_vld  = 1'b1;
                end else begin
                    e_dout = 1'b0;
                    e_vld  = 1'b0;
                end
                if (m_acc) begin
                    hist.push_back(din);
                    m_n = hist.size() - 1;
                    m_a = parity_at(m_n, TG0);
                    m_b = parity_at(m_n, TG1);
                    m_k = tb_keep(mrate, m_n);
                    if (m_k[1]) q.push_back(m_a);
                    if (m_k[0]) q.push_back(m_b);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("out_valid", 32'(dvld), 32'(e_vld));
                chk("out_bit", 32'(dout), 32'(e_dout));
                chk("in_ready", 32'(rdy), 32'(q.size() != 2));
            end
            if (cap_en && dvld) cap.push_back(dout);
            if (bp_mon) begin
                if (dvld) bp_seen = 1'b1;
                else if (bp_seen) bp_gaps++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Present a bit and hold it until the block accepts it.
    task automatic send(input logic d, input logic st, input logic [1:0] rt);
        int   tries;
        logic r;
        din   = d;
        vin   = 1'b1;
        start = st;
        rate  = rt;
        tries = 0;
        do begin
            r = (q.size() != 2);
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            tries++;
        end while (!r && tries < 8);
        if (!r) chk("send_timeout", 32'(r), 32'd1);
    endtask

    task automatic idle(input int n);
        vin   = 1'b0;
        start = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic impulse(input string tag, input logic [1:0] rt, input int nin,
                           input int nexp, input logic [31:0] exp_bits);
        logic [31:0] v;
        cap.delete();
        cap_en = 1'b1;
        send(1'b1, 1'b1, rt);
        for (int i = 1; i < nin; i++) send(1'b0, 1'b0, rt);
        idle(8);
        cap_en = 1'b0;
        chk({tag, "_len"}, 32'(cap.size()), 32'(nexp));
        v = 32'd0;
        for (int i = 0; i < cap.size() && i < 32; i++) v = {v[30:0], cap[i]};
        chk(tag, v, exp_bits);
    endtask

    logic last_acc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rate  = 2'b00;
        din   = 1'b0;
        vin   = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(dvld), 32'd0);
        chk("rst_out", 32'(dout), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);

        impulse("imp_r12", 2'b00, 8, 16, 32'b1101111100101100);
        impulse("imp_r34", 2'b10, 6, 8, 32'b11011100);
        impulse("imp_r23", 2'b01, 4, 6, 32'b110111);
        impulse("imp_r11", 2'b11, 8, 16, 32'b1101111100101100);

        // continuous VALID at rate 1/2: output must never gap once started
        bp_gaps = 0;
        bp_seen = 1'b0;
        bp_mon  = 1'b1;
        send(1'($urandom_range(0, 1)), 1'b1, 2'b00);
        for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
        bp_mon = 1'b0;
        chk("bp_gaps", 32'(bp_gaps), 32'd0);
        idle(6);

        // Start coinciding with an accepted bit in the middle of a stream
        send(1'b1, 1'b1, 2'b10);
        send(1'b0, 1'b0, 2'b10);
        send(1'b1, 1'b1, 2'b01);
        send(1'b1, 1'b0, 2'b01);
        send(1'b0, 1'b0, 2'b01);
        idle(6);

        // randomized traffic; a refused bit is held until accepted
        last_acc = 1'b1;
        vin      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!vin || last_acc) begin
                vin = ($urandom_range(0, 3) != 0);
                din = 1'($urandom_range(0, 1));
            end
            start    = ($urandom_range(0, 49) == 0);
            rate     = 2'($urandom_range(0, 3));
            last_acc = vin && (q.size() != 2);
            @(negedge clock);
        end
        idle(6);

        // asynchronous reset between edges in the middle of a packet
        send(1'b1, 1'b1, 2'b00);
        send(1'b0, 1'b0, 2'b00);
        send(1'b1, 1'b0, 2'b00);
        vin = 1'b1;
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dvld), 32'd0);
        chk("arst_ready", 32'(rdy), 32'd1);
        vin = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        impulse("imp_after_rst", 2'b00, 8, 16, 32'b1101111100101100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
